// File: rtl/dm_responder.sv
// dm_responder: memory-side responder for the CPU data-memory request interface.
// Takes one load/store at a time, waits WAIT_CYCLES extra cycles, then performs
// a little-endian word/half/byte access on an internal RAM and presents the
// result on a valid/ready response channel until the initiator consumes it.
module dm_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    state_t      state;
    state_t      state_next;
    logic [3:0]  counter;

    // Request fields captured at acceptance; the bus is don't-care afterwards.
    logic        cap_we;
    logic [1:0]  cap_size;
    logic        cap_sign;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic [31:0] ram [DEPTH];

    logic                  accept;
    logic                  access;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [1:0]            lane;
    logic [31:0]           cur_word;
    logic [31:0]           lane_word;
    logic                  acc_err;
    logic [3:0]            byte_en;
    logic [31:0]           wr_data;
    logic [31:0]           store_word;
    logic [31:0]           load_data;

    assign accept   = (state == IDLE) && req_valid;
    assign access   = (state == BUSY) && (counter == 4'd0);
    assign word_idx = cap_addr[ADDR_WIDTH-1:2];
    assign lane     = cap_addr[1:0];
    assign cur_word = ram[word_idx];

    // State register; reset wins over any in-flight request.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples pre-edge values regardless of process ordering.
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, wait for consumer in RESP.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned
        // (which would infer a latch).
        state_next = state;
        case (state)
            IDLE:    if (req_valid)      state_next = BUSY;
            BUSY:    if (counter == 4'd0) state_next = RESP;
            RESP:    if (resp_ready)     state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // Handshake outputs are pure functions of the state.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE:    req_ready  = 1'b1;
            RESP:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Latency counter and request capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            counter   <= 4'd0;
            cap_we    <= 1'b0;
            cap_size  <= 2'b00;
            cap_sign  <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
        end else if (accept) begin
            counter   <= 4'(WAIT_CYCLES);
            cap_we    <= req_we;
            cap_size  <= req_size;
            cap_sign  <= req_sign;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
        end else if (state == BUSY && counter != 4'd0) begin
            counter <= counter - 4'd1;
        end
    end

    // Access decode: error checks, store lane merge, load lane extract and extend.
    always_comb begin
        acc_err = 1'b0;
        if (cap_size == 2'b11)                          acc_err = 1'b1;
        if (|cap_addr[31:ADDR_WIDTH])                   acc_err = 1'b1;
        if (cap_size == SZ_HALF && cap_addr[0])         acc_err = 1'b1;
        if (cap_size == SZ_WORD && cap_addr[1:0] != 2'b00) acc_err = 1'b1;

        byte_en = 4'b0000;
        wr_data = cap_wdata;
        case (cap_size)
            SZ_WORD: byte_en = 4'b1111;
            SZ_HALF: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{cap_wdata[15:0]}};
            end
            SZ_BYTE: begin
                byte_en = 4'b0001 << lane;
                wr_data = {4{cap_wdata[7:0]}};
            end
            default: ;
        endcase
        for (int b = 0; b < 4; b++) begin
            store_word[8*b +: 8] = byte_en[b] ? wr_data[8*b +: 8] : cur_word[8*b +: 8];
        end

        lane_word = cur_word >> {lane, 3'b000};
        case (cap_size)
            SZ_HALF: load_data = cap_sign ? {{16{lane_word[15]}}, lane_word[15:0]}
                                          : {16'd0, lane_word[15:0]};
            SZ_BYTE: load_data = cap_sign ? {{24{lane_word[7]}}, lane_word[7:0]}
                                          : {24'd0, lane_word[7:0]};
            default: load_data = cur_word;
        endcase
    end

    // RAM: cleared by reset, written only by an error-free store at access time.
    always_ff @(posedge clk) begin
        // NOTE: the memory is reset on purpose (reset must clear every word);
        // this rules out mapping it onto block RAM.
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram[i] <= 32'd0;
            end
        end else if (access && cap_we && !acc_err) begin
            ram[word_idx] <= store_word;
        end
    end

    // Response registers: loaded at access time and held through RESP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if (access) begin
            resp_err   <= acc_err;
            resp_rdata <= (acc_err || cap_we) ? 32'd0 : load_data;
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed stimulus with a scoreboard queue. The driver pushes
// the hand-computed response for each request; a monitor on the falling edge
// compares every presented response against the queue head and checks latency.
module tb_dm_responder;

    localparam int ADDR_WIDTH  = 12;
    localparam int WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;
    int acc_edge = 0;
    int hs_edge  = 0;
    bit prev_valid = 1'b0;

    dm_responder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_sign  (req_sign),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: compare every presented response with the scoreboard head.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (!prev_valid)
                check("latency", 32'(edge_cnt - acc_edge), 32'(WAIT_CYCLES + 1));
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got rdata 0x%08h err %0b with nothing outstanding",
                         resp_rdata, resp_err);
            end else begin
                check("resp_rdata", resp_rdata, exp_q[0].rdata);
                check("resp_err", 32'(resp_err), 32'(exp_q[0].err));
                if (resp_ready) begin
                    void'(exp_q.pop_front());
                    hs_edge = edge_cnt + 1;
                end
            end
        end
        prev_valid = resp_valid;
    end

    // Issue one request and return just after its accepting edge.
    task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input bit keep_valid);
        bit got;
        exp_q.push_back('{rdata: exp_rdata, err: exp_err});
        req_we    = we;
        req_size  = size;
        req_sign  = sign;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc_edge = edge_cnt + 1;
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            check("accept_timeout", 32'd0, 32'd1);
            void'(exp_q.pop_back());
        end
        if (!keep_valid || !got) req_valid = 1'b0;
    endtask

    task automatic wait_resp_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = resp_valid;
        end
        if (!seen) check("resp_valid_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 200 && !empty; i++) begin
            @(negedge clk);
            empty = (exp_q.size() == 0);
        end
        if (!empty) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic load(input logic [1:0] size, input logic sign, input logic [31:0] addr,
                        input logic [31:0] exp_rdata, input logic exp_err);
        issue(1'b0, size, sign, addr, 32'hDEAD_BEEF, exp_rdata, exp_err, 1'b0);
        drain();
    endtask

    task automatic store(input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_err);
        issue(1'b1, size, 1'b0, addr, wdata, 32'd0, exp_err, 1'b0);
        drain();
    endtask

    initial begin
        int first_hs;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_sign   = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        @(posedge clk);
        #1;

        // Reset while a response is held: RAM cleared, handshake back to IDLE.
        resp_ready = 1'b0;
        issue(1'b1, 2'b00, 1'b0, 32'h40, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
        wait_resp_valid();
        pulse_reset();
        @(negedge clk);
        check("hold_rst_req_ready", 32'(req_ready), 32'd1);
        check("hold_rst_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        load(2'b00, 1'b0, 32'h40, 32'd0, 1'b0);

        // Reset while BUSY: the store is dropped.
        issue(1'b1, 2'b00, 1'b0, 32'h44, 32'h1111_2222, 32'd0, 1'b0, 1'b0);
        pulse_reset();
        repeat (4) @(posedge clk);
        #1;
        load(2'b00, 1'b0, 32'h44, 32'd0, 1'b0);

        // Word store with response held for 4 cycles, then read back.
        resp_ready = 1'b0;
        issue(1'b1, 2'b00, 1'b0, 32'h10, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        wait_resp_valid();
        repeat (4) @(posedge clk);
        #1;
        resp_ready = 1'b1;
        drain();
        load(2'b00, 1'b0, 32'h10, 32'h1234_5678, 1'b0);

        // Byte lane and extension.
        store(2'b10, 32'h13, 32'h0000_00AB, 1'b0);
        load(2'b10, 1'b1, 32'h13, 32'hFFFF_FFAB, 1'b0);
        load(2'b10, 1'b0, 32'h13, 32'h0000_00AB, 1'b0);
        load(2'b00, 1'b0, 32'h10, 32'hAB34_5678, 1'b0);
        load(2'b10, 1'b0, 32'h11, 32'h0000_0056, 1'b0);

        // Half lane and extension.
        store(2'b01, 32'h22, 32'h0000_8001, 1'b0);
        load(2'b01, 1'b1, 32'h22, 32'hFFFF_8001, 1'b0);
        load(2'b01, 1'b0, 32'h22, 32'h0000_8001, 1'b0);
        load(2'b00, 1'b0, 32'h20, 32'h8001_0000, 1'b0);

        // Errors leave RAM word @0x24 untouched.
        store(2'b00, 32'h24, 32'h1122_3344, 1'b0);
        store(2'b00, 32'h26, 32'hFFFF_FFFF, 1'b1);
        load(2'b01, 1'b0, 32'h21, 32'd0, 1'b1);
        load(2'b11, 1'b0, 32'h24, 32'd0, 1'b1);
        store(2'b11, 32'h24, 32'hFFFF_FFFF, 1'b1);
        store(2'b00, 32'h0000_1000, 32'hFFFF_FFFF, 1'b1);
        store(2'b00, 32'h0000_1024, 32'hFFFF_FFFF, 1'b1);
        load(2'b00, 1'b0, 32'h0000_1024, 32'd0, 1'b1);
        load(2'b00, 1'b0, 32'h24, 32'h1122_3344, 1'b0);
        load(2'b00, 1'b0, 32'h00, 32'd0, 1'b0);

        // Back-to-back with req_valid held and resp_ready tied high.
        issue(1'b1, 2'b00, 1'b0, 32'h30, 32'hA5A5_A5A5, 32'd0, 1'b0, 1'b1);
        issue(1'b1, 2'b00, 1'b0, 32'h34, 32'h5A5A_5A5A, 32'd0, 1'b0, 1'b0);
        first_hs = hs_edge;
        check("b2b_accept_edge", 32'(acc_edge), 32'(first_hs + 1));
        drain();
        load(2'b00, 1'b0, 32'h30, 32'hA5A5_A5A5, 1'b0);
        load(2'b00, 1'b0, 32'h34, 32'h5A5A_5A5A, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Responder (memory side) of the CPU data-memory request interface; the CPU datapath is the initiator.
- Accepts one load/store request at a time over a valid/ready handshake and waits a programmable latency.
- Performs a little-endian word/half/byte access on an internal RAM, then returns read data and error status over a valid/ready response channel.
- Replaces the zero-latency data memory when the core moves to a stalling memory interface.

Parameters:
- ADDR_WIDTH, 12, byte-address bits decoded; RAM holds 2^(ADDR_WIDTH-2) 32-bit words.
- WAIT_CYCLES, 2, extra cycles between acceptance and access (0..15).

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset (0 at a rising edge resets the block)
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 word, 01 half, 10 byte, 11 reserved
- req_sign  input  1  loads of half/byte: 1 sign-extend, 0 zero-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  output  1  response present
- resp_ready  input  1  initiator consumes response
- resp_rdata  output  32  load result, 0 for stores and errors
- resp_err  output  1  request was rejected (no memory effect)

Behaviour:
- States: IDLE, BUSY, RESP. req_ready = (state==IDLE). resp_valid = (state==RESP).
- Reset (reset==0 at an edge):
  - state goes to IDLE; counter = 0; resp_rdata = 0; resp_err = 0.
  - Every RAM word is cleared to 0.
  - Reset has priority over everything. A request in flight is dropped, and a pending store is not committed.
- IDLE: on an edge with req_valid=1, capture we, size, sign, addr and wdata; load counter = WAIT_CYCLES; go to BUSY. Inputs are don't-care after capture.
- BUSY:
  - Each edge with counter != 0 decrements the counter.
  - On the edge with counter == 0, evaluate the request, commit a store / register load data, and go to RESP.
  - Acceptance-edge to RESP-edge distance is exactly WAIT_CYCLES+1 edges.
- RESP: outputs are held stable. On an edge with resp_ready=1, go to IDLE. No new request is accepted in that same edge; the earliest next accept is the following edge.
- req_valid during BUSY/RESP is ignored (req_ready=0).
- Error checks, evaluated at access time:
  - size==11 → error.
  - addr[31:ADDR_WIDTH] != 0 → error.
  - Half with addr[0]=1 → error.
  - Word with addr[1:0] != 0 → error.
  - On error: resp_err=1, resp_rdata=0, RAM unchanged. Full latency still applies.
- Store, word index = addr[ADDR_WIDTH-1:2]:
  - word: whole word written.
  - half: addr[1]=0 writes bits[15:0], =1 writes [31:16], from wdata[15:0].
  - byte: addr[1:0]=k writes bits[8k+7:8k] from wdata[7:0].
  - Untouched bytes keep their value.
  - resp_rdata=0, resp_err=0.
- Load:
  - Same lane selection as stores.
  - Result is right-aligned, then extended per req_sign (ignored for word).
  - Data reflects all earlier committed stores.

Test Plan:
- Reset while RESP is held with resp_ready=0 → next cycle req_ready=1, resp_valid=0; a load of any prior address returns 0.
- WAIT_CYCLES=2. Store word 0x12345678 @0x10, accepted edge E0 → resp_valid first high after E3, resp_err=0. Hold resp_ready=0 for 4 cycles → outputs stable. Then load word @0x10 → resp_rdata=0x12345678.
- After the above: store byte 0xAB @0x13, then load byte @0x13 with sign=1 → 0xFFFFFFAB; with sign=0 → 0x000000AB. Load word @0x10 → 0xAB345678.
- Store half 0x8001 @0x22, then load half @0x22 with sign=1 → 0xFFFF8001. Load word @0x20 → 0x80010000.
- Errors each give resp_err=1, resp_rdata=0, with RAM word @0x24 unchanged afterwards:
  - store word @0x26 (misaligned)
  - load half @0x21 (misaligned)
  - size=11
  - addr 0x00001000 (out of range, ADDR_WIDTH=12)
- Back-to-back: req_valid held high across two requests with resp_ready tied 1 → second accept occurs exactly one edge after the first RESP→IDLE edge. No request is lost or duplicated (store count 2 → 2 RAM updates).
